// File: rtl/riscv_pkg.sv
// Shared types for the writeback stage: load sizes, FSM states and the
// latched descriptor of the one load that may be outstanding.
package riscv_pkg;

   typedef enum logic [1:0] {
      LS_BYTE = 2'b00,
      LS_HALF = 2'b01,
      LS_WORD = 2'b10
   } load_size_t;

   typedef enum logic {
      WB_IDLE      = 1'b0,
      WB_WAIT_LOAD = 1'b1
   } wb_state_t;

   // size is kept as raw bits so the unnamed 2'b11 code survives to the aligner
   typedef struct packed {
      logic [4:0] rd;
      logic [1:0] size;
      logic       is_unsigned;
      logic [1:0] addr_lo;
   } load_req_t;

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load aligner: picks the addressed byte/half out of a
// naturally aligned memory word and sign- or zero-extends it.
module riscv_load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  addr_lo_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        byte_sign;
   logic        half_sign;

   always_comb begin
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
   end

   // addr_lo[0] is irrelevant for halves; misalignment traps upstream
   assign half_sel  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   assign byte_sign = byte_sel[7] & ~unsigned_i;
   assign half_sign = half_sel[15] & ~unsigned_i;

   always_comb begin
      case (size_i)
         LS_BYTE: data_o = {{24{byte_sign}}, byte_sel};
         LS_HALF: data_o = {{16{half_sign}}, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/riscv_writeback.sv
// Writeback stage: retires instructions from the memory stage, waits for the
// dmem response on loads and drives the regfile write port from flops.
module riscv_writeback
   import riscv_pkg::*;
#(
   parameter int INSTRET_W = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ex_valid_i,
   output logic                 ex_ready_o,
   input  logic [4:0]           ex_rd_i,
   input  logic [31:0]          ex_result_i,
   input  logic                 ex_is_load_i,
   input  logic [1:0]           ex_load_size_i,
   input  logic                 ex_load_unsigned_i,
   input  logic [1:0]           ex_addr_lo_i,
   input  logic                 dmem_rvalid_i,
   input  logic [31:0]          dmem_rdata_i,
   output logic [31:0]          w_data_o,
   output logic [4:0]           w_addr_o,
   output logic                 w_enable_o,
   output logic                 pend_valid_o,
   output logic [4:0]           pend_rd_o,
   output logic [INSTRET_W-1:0] instret_o,
   output logic                 err_o
);

   wb_state_t   state_q;
   wb_state_t   state_d;
   load_req_t   ld_q;

   logic        accept;
   logic        retire_alu;
   logic        retire_ld;
   logic        retire;
   logic        stray_rsp;
   logic [4:0]  ret_rd;
   logic [31:0] ret_data;
   logic [31:0] ld_data;

   assign accept     = ex_valid_i && ex_ready_o;
   assign retire_alu = accept && !ex_is_load_i;
   assign retire_ld  = (state_q == WB_WAIT_LOAD) && dmem_rvalid_i;
   assign retire     = retire_alu || retire_ld;
   assign stray_rsp  = (state_q == WB_IDLE) && dmem_rvalid_i;
   assign ret_rd     = retire_ld ? ld_q.rd : ex_rd_i;
   assign ret_data   = retire_ld ? ld_data : ex_result_i;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= WB_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_IDLE:      if (accept && ex_is_load_i) state_d = WB_WAIT_LOAD;
         WB_WAIT_LOAD: if (dmem_rvalid_i)          state_d = WB_IDLE;
         default:                                  state_d = WB_IDLE;
      endcase
   end

   // Stalling during the rvalid cycle costs one bubble after each load but
   // keeps the regfile write port single-sourced per cycle.
   always_comb begin
      ex_ready_o   = 1'b0;
      pend_valid_o = 1'b0;
      case (state_q)
         WB_IDLE:      ex_ready_o   = 1'b1;
         WB_WAIT_LOAD: pend_valid_o = 1'b1;
         default:      ex_ready_o   = 1'b0;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ld_q <= '0;
      end else if (accept && ex_is_load_i) begin
         ld_q.rd          <= ex_rd_i;
         ld_q.size        <= ex_load_size_i;
         ld_q.is_unsigned <= ex_load_unsigned_i;
         ld_q.addr_lo     <= ex_addr_lo_i;
      end
   end

   assign pend_rd_o = ld_q.rd;

   riscv_load_align u_align (
      .rdata_i    (dmem_rdata_i),
      .size_i     (ld_q.size),
      .unsigned_i (ld_q.is_unsigned),
      .addr_lo_i  (ld_q.addr_lo),
      .data_o     (ld_data)
   );

   // x0 writes are suppressed; addr/data only move when a write is issued
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_enable_o <= 1'b0;
         w_addr_o   <= '0;
         w_data_o   <= '0;
      end else begin
         w_enable_o <= retire && (ret_rd != 5'd0);
         if (retire && (ret_rd != 5'd0)) begin
            w_addr_o <= ret_rd;
            w_data_o <= ret_data;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       instret_o <= '0;
      else if (retire) instret_o <= instret_o + INSTRET_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)          err_o <= 1'b0;
      else if (stray_rsp) err_o <= 1'b1;
   end

endmodule

// File: tb/tb_riscv_writeback.sv
// Scoreboard bench for riscv_writeback: expected regfile writes are queued at
// issue time and matched against every w_enable_o pulse.
module tb_riscv_writeback;

   localparam int IW = 8;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          ex_valid_i = 1'b0;
   logic          ex_ready_o;
   logic [4:0]    ex_rd_i = '0;
   logic [31:0]   ex_result_i = '0;
   logic          ex_is_load_i = 1'b0;
   logic [1:0]    ex_load_size_i = '0;
   logic          ex_load_unsigned_i = 1'b0;
   logic [1:0]    ex_addr_lo_i = '0;
   logic          dmem_rvalid_i = 1'b0;
   logic [31:0]   dmem_rdata_i = '0;
   logic [31:0]   w_data_o;
   logic [4:0]    w_addr_o;
   logic          w_enable_o;
   logic          pend_valid_o;
   logic [4:0]    pend_rd_o;
   logic [IW-1:0] instret_o;
   logic          err_o;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   riscv_writeback #(.INSTRET_W(IW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_rd_i(ex_rd_i),
      .ex_result_i(ex_result_i), .ex_is_load_i(ex_is_load_i),
      .ex_load_size_i(ex_load_size_i), .ex_load_unsigned_i(ex_load_unsigned_i),
      .ex_addr_lo_i(ex_addr_lo_i), .dmem_rvalid_i(dmem_rvalid_i),
      .dmem_rdata_i(dmem_rdata_i), .w_data_o(w_data_o), .w_addr_o(w_addr_o),
      .w_enable_o(w_enable_o), .pend_valid_o(pend_valid_o), .pend_rd_o(pend_rd_o),
      .instret_o(instret_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   // every write pulse must match the oldest expected write
   always @(negedge clk_i) begin
      if (!rst_i && w_enable_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got addr=%0d data=%h, none expected", w_addr_o, w_data_o);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (w_addr_o !== e.a || w_data_o !== e.d) begin
               errors++;
               $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h", w_addr_o, w_data_o, e.a, e.d);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic do_reset();
      ex_valid_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      rst_i         = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      if (a != 5'd0) exp_q.push_back(e);
   endtask

   task automatic issue(input logic [4:0] rd, input logic [31:0] res, input logic ld,
                        input logic [1:0] sz, input logic uns, input logic [1:0] al);
      ex_valid_i = 1'b1;
      ex_rd_i = rd;
      ex_result_i = res;
      ex_is_load_i = ld;
      ex_load_size_i = sz;
      ex_load_unsigned_i = uns;
      ex_addr_lo_i = al;
      @(posedge clk_i);
      #1 ex_valid_i = 1'b0;
   endtask

   task automatic run_load(input string nm, input logic [4:0] rd, input logic [1:0] sz,
                           input logic uns, input logic [1:0] al, input logic [31:0] rdata,
                           input int delay, input logic [31:0] exp_d);
      push_exp(rd, exp_d);
      issue(rd, 32'h0, 1'b1, sz, uns, al);
      for (int i = 0; i < delay; i++) begin
         checks++;
         if (ex_ready_o !== 1'b0 || pend_valid_o !== 1'b1 || pend_rd_o !== rd) begin
            errors++;
            $display("FAIL %s_wait got ready=%b pend=%b prd=%0d exp ready=0 pend=1 prd=%0d",
                     nm, ex_ready_o, pend_valid_o, pend_rd_o, rd);
         end
         if (i == delay - 1) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = rdata;
         end
         @(posedge clk_i);
         #1;
      end
      dmem_rvalid_i = 1'b0;
      checks++;
      if (w_enable_o !== (rd != 5'd0) || pend_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL %s_done got wen=%b pend=%b ready=%b exp wen=%b pend=0 ready=1",
                  nm, w_enable_o, pend_valid_o, ex_ready_o, rd != 5'd0);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (w_enable_o !== 1'b0 || w_data_o !== 32'h0 || w_addr_o !== 5'd0 || pend_valid_o !== 1'b0 ||
          pend_rd_o !== 5'd0 || instret_o !== '0 || err_o !== 1'b0 || ex_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset got wen=%b wd=%h wa=%0d pend=%b prd=%0d ir=%0d err=%b ready=%b exp all 0, ready=1",
                  w_enable_o, w_data_o, w_addr_o, pend_valid_o, pend_rd_o, instret_o, err_o, ex_ready_o);
      end
      do_reset();
   endtask

   task automatic test_nonload();
      do_reset();
      push_exp(5'd5, 32'h0000_1234);
      issue(5'd5, 32'h0000_1234, 1'b0, 2'b00, 1'b0, 2'b00);
      checks++;
      if (w_enable_o !== 1'b1 || instret_o !== 8'd1) begin
         errors++;
         $display("FAIL addi got wen=%b ir=%0d exp wen=1 ir=1", w_enable_o, instret_o);
      end
      issue(5'd0, 32'hDEAD_BEEF, 1'b0, 2'b00, 1'b0, 2'b00);
      checks++;
      if (w_enable_o !== 1'b0 || instret_o !== 8'd2 || w_data_o !== 32'h0000_1234) begin
         errors++;
         $display("FAIL x0_write got wen=%b ir=%0d wd=%h exp wen=0 ir=2 wd=00001234", w_enable_o, instret_o, w_data_o);
      end
   endtask

   task automatic test_loads();
      do_reset();
      run_load("lb",   5'd7, 2'b00, 1'b0, 2'd3, 32'h80FF_0011, 4, 32'hFFFF_FF80);
      run_load("lbu",  5'd7, 2'b00, 1'b1, 2'd3, 32'h80FF_0011, 4, 32'h0000_0080);
      run_load("lb0",  5'd8, 2'b00, 1'b0, 2'd0, 32'h80FF_0011, 1, 32'h0000_0011);
      run_load("lb2",  5'd8, 2'b00, 1'b0, 2'd2, 32'h80FF_0011, 2, 32'hFFFF_FFFF);
      run_load("lh",   5'd9, 2'b01, 1'b0, 2'd2, 32'h9ABC_0000, 2, 32'hFFFF_9ABC);
      run_load("lhu",  5'd9, 2'b01, 1'b1, 2'd2, 32'h9ABC_0000, 3, 32'h0000_9ABC);
      run_load("lh0",  5'd9, 2'b01, 1'b0, 2'd1, 32'h9ABC_7001, 1, 32'h0000_7001);
      run_load("lw",   5'd10, 2'b10, 1'b0, 2'd3, 32'h9ABC_0000, 1, 32'h9ABC_0000);
      run_load("lsz3", 5'd11, 2'b11, 1'b1, 2'd1, 32'h8123_4567, 2, 32'h8123_4567);
      run_load("lx0",  5'd0, 2'b10, 1'b0, 2'd0, 32'h1111_2222, 3, 32'h0);
      checks++;
      if (instret_o !== 8'd10 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL load_count got ir=%0d err=%b exp ir=10 err=0", instret_o, err_o);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         push_exp(5'(i), 32'hA000_0000 + 32'(i));
         ex_valid_i = 1'b1;
         ex_is_load_i = 1'b0;
         ex_rd_i = 5'(i);
         ex_result_i = 32'hA000_0000 + 32'(i);
         @(posedge clk_i);
         #1;
         checks++;
         if (w_enable_o !== 1'b1 || w_addr_o !== 5'(i) || ex_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d got wen=%b wa=%0d ready=%b exp wen=1 wa=%0d ready=1", i, w_enable_o, w_addr_o, ex_ready_o, i);
         end
      end
      ex_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      checks++;
      if (w_enable_o !== 1'b0 || instret_o !== 8'd4) begin
         errors++;
         $display("FAIL b2b_end got wen=%b ir=%0d exp wen=0 ir=4", w_enable_o, instret_o);
      end
   endtask

   task automatic test_instret_wrap();
      do_reset();
      ex_valid_i = 1'b1;
      ex_is_load_i = 1'b0;
      ex_rd_i = 5'd0;
      repeat (256) @(posedge clk_i);
      #1;
      checks++;
      if (instret_o !== 8'd0) begin
         errors++;
         $display("FAIL instret_wrap got %0d exp 0", instret_o);
      end
      @(posedge clk_i);
      #1 ex_valid_i = 1'b0;
      checks++;
      if (instret_o !== 8'd1) begin
         errors++;
         $display("FAIL instret_after_wrap got %0d exp 1", instret_o);
      end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      push_exp(5'd3, 32'h0000_0042);
      issue(5'd3, 32'h0000_0042, 1'b0, 2'b00, 1'b0, 2'b00);
      issue(5'd12, 32'h0, 1'b1, 2'b10, 1'b0, 2'b00);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      exp_q.delete();
      #1;
      checks++;
      if (w_enable_o !== 1'b0 || w_data_o !== 32'h0 || w_addr_o !== 5'd0 || pend_valid_o !== 1'b0 ||
          pend_rd_o !== 5'd0 || instret_o !== '0 || err_o !== 1'b0 || ex_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL midload_reset got wen=%b wd=%h wa=%0d pend=%b prd=%0d ir=%0d err=%b ready=%b exp all 0, ready=1",
                  w_enable_o, w_data_o, w_addr_o, pend_valid_o, pend_rd_o, instret_o, err_o, ex_ready_o);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h5555_AAAA;
      @(posedge clk_i);
      #1 dmem_rvalid_i = 1'b0;
      checks++;
      if (err_o !== 1'b1 || w_enable_o !== 1'b0 || instret_o !== '0) begin
         errors++;
         $display("FAIL late_rvalid got err=%b wen=%b ir=%0d exp err=1 wen=0 ir=0", err_o, w_enable_o, instret_o);
      end
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if (err_o !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky got %b exp 1", err_o);
      end
   endtask

   initial begin
      test_reset();
      test_nonload();
      test_loads();
      test_back_to_back();
      test_instret_wrap();
      test_reset_mid_load();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending writes exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_writeback.md
Name: riscv_writeback

Overview:
- Final pipeline stage of the RISC-V core.
- Accepts retiring instructions from the memory stage over a valid/ready handshake and waits for the data-memory response on loads.
- Aligns and sign/zero-extends load data, then drives the register file write port from registered outputs.
- Exposes the pending-load destination for hazard interlock and counts retired instructions.

Parameters:
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- ex_valid_i  in  1  memory stage presents a retiring instruction
- ex_ready_o  out  1  writeback accepts the instruction this cycle
- ex_rd_i  in  5  destination register
- ex_result_i  in  32  ALU/CSR/link result for non-loads
- ex_is_load_i  in  1  instruction is a load
- ex_load_size_i  in  2  load_size_t: LS_BYTE / LS_HALF / LS_WORD
- ex_load_unsigned_i  in  1  zero-extend (LBU/LHU)
- ex_addr_lo_i  in  2  byte address bits [1:0] of the load
- dmem_rvalid_i  in  1  data memory read response valid
- dmem_rdata_i  in  32  data memory read word (naturally aligned)
- w_data_o  out  32  regfile write data
- w_addr_o  out  5  regfile write address
- w_enable_o  out  1  regfile write strobe
- pend_valid_o  out  1  a load is outstanding
- pend_rd_o  out  5  rd of the outstanding load
- instret_o  out  INSTRET_W  retired instruction count
- err_o  out  1  sticky: dmem response arrived with no load outstanding

Behaviour:
- Reset values:
  - State is IDLE.
  - w_enable_o, w_data_o, w_addr_o, pend_valid_o, pend_rd_o, instret_o and err_o are all 0.
  - ex_ready_o is 1.
- States:
  - IDLE:
    - ex_ready_o = 1.
    - Handshake occurs when ex_valid_i && ex_ready_o.
    - Non-load: next cycle w_enable_o = (ex_rd_i != 0), w_addr_o = ex_rd_i, w_data_o = ex_result_i; instret increments by 1. Latency is 1 cycle.
    - Load: latch rd, size, unsigned flag and addr_lo; go to WAIT_LOAD. pend_valid_o = 1 and pend_rd_o = rd from the next cycle.
  - WAIT_LOAD:
    - ex_ready_o = 0.
    - On dmem_rvalid_i: next cycle w_enable_o = (rd != 0), w_data_o = aligned data; instret increments; state returns to IDLE; pend_valid_o clears in that same cycle.
    - Minimum load latency is 1 cycle after rvalid. No bound on rvalid delay.
- w_enable_o is a single-cycle pulse per retired instruction. w_addr_o and w_data_o hold their last values when w_enable_o = 0.
- Back-to-back non-loads:
  - One write per cycle at full throughput.
  - After a load there is at least one bubble, because ex_ready_o stays 0 during the rvalid cycle.
- Load alignment:
  - LS_BYTE: select byte addr_lo; bit 7 extended unless unsigned.
  - LS_HALF: select half by addr_lo[1]; addr_lo[0] is ignored (the memory stage traps misalignment); bit 15 extended unless unsigned.
  - LS_WORD: data passes through; addr_lo is ignored.
  - Size encoding 2'b11: treated as LS_WORD.
- rd = 0:
  - No regfile write, but the instruction still retires and instret increments.
  - A load to x0 still waits for rvalid.
- dmem_rvalid_i in IDLE: the response is discarded, err_o sets and stays set until reset, and no write occurs.
- instret wraps modulo 2^INSTRET_W.
- Reset mid-load: the FSM returns to IDLE and the pending load is dropped. A late rvalid then sets err_o.
- Only one load is ever outstanding.

Decomposition:
- riscv_pkg holds:
  - load_size_t enum: LS_BYTE = 2'b00, LS_HALF = 2'b01, LS_WORD = 2'b10.
  - wb_state_t enum: WB_IDLE, WB_WAIT_LOAD.
- Sub-module riscv_load_align is purely combinational: inputs rdata, size, unsigned and addr_lo; output 32-bit data. It is instantiated once.

Test Plan:
- Non-load, ADDI x5 with result 0x0000_1234, valid for 1 cycle → next cycle w_enable_o=1, w_addr_o=5, w_data_o=0x0000_1234; instret_o=1.
- Non-load to x0 with result 0xDEAD_BEEF → w_enable_o stays 0; instret_o increments.
- LB x7, addr_lo=3, rdata 0x80FF_0011 delivered 4 cycles later:
  - ex_ready_o=0 and pend_valid_o=1, pend_rd_o=7 throughout the wait.
  - Cycle after rvalid: w_data_o=0xFFFF_FF80.
  - Repeat as LBU: w_data_o=0x0000_0080.
- LH / LHU with addr_lo=2, rdata 0x9ABC_0000 → 0xFFFF_9ABC / 0x0000_9ABC. LW → 0x9ABC_0000.
- Four back-to-back non-loads to x1..x4 → four consecutive write pulses, no bubbles; instret_o=4.
- Reset mid-load:
  - Issue a load, assert rst_i during WAIT_LOAD → all outputs return to 0 and ex_ready_o=1.
  - Then pulse dmem_rvalid_i → err_o=1, no write.
